// File: rtl/bfly_stage_ctrl.sv
// Beat sequencer for one delay-line butterfly stage: fill/compute enables, bfly_en, valid/frame bookkeeping.
// Optional stall watchdog is compiled in with `define BFLY_CTRL_TIMEOUT_EN.
module bfly_stage_ctrl #(
    parameter int NUM      = 16,
    parameter int DATA     = 256,
    parameter int COUNT    = DATA / NUM,
    parameter int HALF     = COUNT / 2,
    parameter int PIPE_LAT = 1,
    parameter int TIMEOUT  = 64
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       valid_in,
    input  logic                       flush,
    output logic                       sr_write,
    output logic                       sr_read,
    output logic                       bfly_en,
    output logic [$clog2(COUNT)-1:0]   beat_idx,
    output logic                       busy,
    output logic                       valid_out,
    output logic                       frame_done,
    output logic [15:0]                frame_cnt,
    output logic                       err
);

    localparam int IDXW = $clog2(COUNT);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(COUNT - 1);
    localparam logic [IDXW-1:0] FILL_LAST = IDXW'(HALF - 1);

    generate
        if ((COUNT < 2) || (COUNT % 2 != 0) || (PIPE_LAT < 1) || (TIMEOUT < 1)) begin : g_bad_cfg
            $error("bfly_stage_ctrl: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_BFLY
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [IDXW-1:0]   r_beat_idx;
    logic [IDXW-1:0]   w_beat_idx_next;
    logic              w_beat;
    logic              w_sr_write;
    logic              w_sr_read;
    logic              w_frame_inc;
    logic              w_timeout;
    logic              r_bfly_en;
    logic              r_bfly_last;
    logic [PIPE_LAT-1:0] w_vpipe;
    logic [PIPE_LAT-1:0] w_lpipe;
    logic [15:0]       r_frame_cnt;

    // flush suppresses every enable in its own cycle
    assign w_beat = valid_in & ~flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_beat_idx <= '0;
        end else begin
            r_state    <= w_state_next;
            r_beat_idx <= w_beat_idx_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_beat_idx_next = r_beat_idx;
        w_sr_write      = 1'b0;
        w_sr_read       = 1'b0;
        w_frame_inc     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_beat) begin
                    w_sr_write      = 1'b1;
                    w_beat_idx_next = IDXW'(1);
                    w_state_next    = (HALF == 1) ? S_BFLY : S_FILL;
                end
            end
            S_FILL: begin
                if (w_beat) begin
                    w_sr_write      = 1'b1;
                    w_beat_idx_next = r_beat_idx + 1'b1;
                    if (r_beat_idx == FILL_LAST) begin
                        w_state_next = S_BFLY;
                    end
                end
            end
            S_BFLY: begin
                if (w_beat) begin
                    w_sr_read = 1'b1;
                    if (r_beat_idx == LAST_IDX) begin
                        w_state_next    = S_IDLE;
                        w_beat_idx_next = '0;
                        w_frame_inc     = 1'b1;
                    end else begin
                        w_beat_idx_next = r_beat_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next    = S_IDLE;
                w_beat_idx_next = '0;
            end
        endcase
        if (w_timeout || flush) begin
            w_state_next    = S_IDLE;
            w_beat_idx_next = '0;
            w_frame_inc     = 1'b0;
        end
    end

`ifdef BFLY_CTRL_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0] r_stall;
    logic          r_err;

    // fires on the TIMEOUT-th consecutive idle cycle inside a frame
    assign w_timeout = (r_state != S_IDLE) && !valid_in && (r_stall == SW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall <= '0;
            r_err   <= 1'b0;
        end else begin
            if (flush || valid_in || (r_state == S_IDLE) || w_timeout) begin
                r_stall <= '0;
            end else begin
                r_stall <= r_stall + 1'b1;
            end
            if (flush) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bfly_en   <= 1'b0;
            r_bfly_last <= 1'b0;
        end else if (flush || w_timeout) begin
            r_bfly_en   <= 1'b0;
            r_bfly_last <= 1'b0;
        end else begin
            r_bfly_en   <= w_sr_read;
            r_bfly_last <= w_sr_read & (r_beat_idx == LAST_IDX);
        end
    end

    // valid and last-of-frame flag travel together so frame_done lines up with valid_out
    genvar gi;
    generate
        for (gi = 0; gi < PIPE_LAT; gi++) begin : g_pipe
            logic w_v_in;
            logic w_l_in;
            logic r_v;
            logic r_l;
            if (gi == 0) begin : g_head
                assign w_v_in = r_bfly_en;
                assign w_l_in = r_bfly_last;
            end else begin : g_body
                assign w_v_in = w_vpipe[gi-1];
                assign w_l_in = w_lpipe[gi-1];
            end
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    r_v <= 1'b0;
                    r_l <= 1'b0;
                end else if (flush || w_timeout) begin
                    r_v <= 1'b0;
                    r_l <= 1'b0;
                end else begin
                    r_v <= w_v_in;
                    r_l <= w_l_in;
                end
            end
            assign w_vpipe[gi] = r_v;
            assign w_lpipe[gi] = r_l;
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_frame_cnt <= '0;
        end else if (w_frame_inc) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    assign sr_write   = w_sr_write;
    assign sr_read    = w_sr_read;
    assign bfly_en    = r_bfly_en;
    assign beat_idx   = r_beat_idx;
    assign busy       = (r_state != S_IDLE);
    assign valid_out  = w_vpipe[PIPE_LAT-1];
    assign frame_done = w_lpipe[PIPE_LAT-1];
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_bfly_stage_ctrl.sv
// Scoreboard bench for bfly_stage_ctrl (COUNT=16, HALF=8, PIPE_LAT=1, default build without the watchdog).
module tb_bfly_stage_ctrl;

    localparam int COUNT    = 16;
    localparam int HALF     = 8;
    localparam int PIPE_LAT = 1;

    logic        clk;
    logic        rstn;
    logic        valid_in;
    logic        flush;
    logic        sr_write;
    logic        sr_read;
    logic        bfly_en;
    logic [3:0]  beat_idx;
    logic        busy;
    logic        valid_out;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        err;

    bfly_stage_ctrl #(
        .NUM      (16),
        .DATA     (256),
        .PIPE_LAT (PIPE_LAT),
        .TIMEOUT  (64)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .valid_in   (valid_in),
        .flush      (flush),
        .sr_write   (sr_write),
        .sr_read    (sr_read),
        .bfly_en    (bfly_en),
        .beat_idx   (beat_idx),
        .busy       (busy),
        .valid_out  (valid_out),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int cyc;
        bit done;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   m_cnt   = 0;
    int   m_frames = 0;
    bit   m_prev_read = 1'b0;
    int   vo_seen = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_sr_write"},   32'(sr_write),   32'd0);
        check_val({tag, "_sr_read"},    32'(sr_read),    32'd0);
        check_val({tag, "_bfly_en"},    32'(bfly_en),    32'd0);
        check_val({tag, "_beat_idx"},   32'(beat_idx),   32'd0);
        check_val({tag, "_busy"},       32'(busy),       32'd0);
        check_val({tag, "_valid_out"},  32'(valid_out),  32'd0);
        check_val({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check_val({tag, "_frame_cnt"},  32'(frame_cnt),  32'd0);
        check_val({tag, "_err"},        32'(err),        32'd0);
    endtask

    // one clock cycle: drive, check mid-cycle, then advance the reference model
    task automatic step(input bit v, input bit f);
        bit   e_wr;
        bit   e_rd;
        bit   e_vo;
        bit   e_done;
        exp_t ent;
        valid_in = v;
        flush    = f;
        e_wr = v && !f && (m_cnt < HALF);
        e_rd = v && !f && (m_cnt >= HALF);
        @(negedge clk);
        e_vo   = 1'b0;
        e_done = 1'b0;
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            ent    = sb_q.pop_front();
            e_vo   = 1'b1;
            e_done = ent.done;
        end
        check_val("sr_write",   32'(sr_write),   32'(e_wr));
        check_val("sr_read",    32'(sr_read),    32'(e_rd));
        check_val("wr_rd_excl", 32'(sr_write & sr_read), 32'd0);
        check_val("bfly_en",    32'(bfly_en),    32'(m_prev_read));
        check_val("beat_idx",   32'(beat_idx),   32'(m_cnt));
        check_val("busy",       32'(busy),       32'(m_cnt != 0));
        check_val("valid_out",  32'(valid_out),  32'(e_vo));
        check_val("frame_done", 32'(frame_done), 32'(e_done));
        check_val("frame_cnt",  32'(frame_cnt),  32'(m_frames & 16'hFFFF));
        check_val("err",        32'(err),        32'd0);
        if (valid_out === 1'b1) vo_seen++;
        if (e_done) begin
            check_val("vo_per_frame", 32'(vo_seen), 32'(HALF));
            $display("frame done: cycle=%0d frame_cnt=%0d valid_out_beats=%0d", cyc, frame_cnt, vo_seen);
            vo_seen = 0;
        end
        @(posedge clk);
        if (f) begin
            m_cnt       = 0;
            m_prev_read = 1'b0;
            vo_seen     = 0;
            sb_q.delete();
        end else begin
            m_prev_read = e_rd;
            if (v) begin
                if (e_rd) begin
                    ent.cyc  = cyc + 1 + PIPE_LAT;
                    ent.done = (m_cnt == COUNT - 1);
                    sb_q.push_back(ent);
                end
                if (m_cnt == COUNT - 1) begin
                    m_cnt = 0;
                    m_frames++;
                end else begin
                    m_cnt++;
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic async_reset_mid_cycle();
        valid_in = 1'b1;
        flush    = 1'b0;
        #2;
        rstn     = 1'b0;
        valid_in = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        m_cnt       = 0;
        m_frames    = 0;
        m_prev_read = 1'b0;
        vo_seen     = 0;
        sb_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        rstn     = 1'b1;
        valid_in = 1'b0;
        flush    = 1'b0;
        #1;
        rstn = 1'b0;
        #2;
        check_reset_outputs("reset");
        #5;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // single frame
        repeat (COUNT) step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);

        // three back-to-back frames
        repeat (3 * COUNT) step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);

        // gaps in FILL and in BFLY
        repeat (5) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        repeat (7) step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        repeat (4) step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);

        // flush landing on beat 10, then a clean frame
        repeat (10) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        repeat (COUNT) step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);

        // flush right after the last beat drops the pending frame_done
        repeat (COUNT) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0);

        // async reset while beat 5 of FILL is on the input
        repeat (5) step(1'b1, 1'b0);
        async_reset_mid_cycle();
        repeat (COUNT) step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);

        // long stall is held when the watchdog is not built
        repeat (6) step(1'b1, 1'b0);
        repeat (64) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0);

        // random traffic with occasional flushes
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        end

        for (int i = 0; i < 8 && sb_q.size() > 0; i++) begin
            step(1'b0, 1'b0);
        end
        check_val("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
